display_scan_ctrl: RTL and testbench

//  Scans a multiplexed common-anode 7-segment display from the one-cycle refresh strobe made by the display

---
 rtl/disp_pkg.sv | 21 ++
 rtl/seg7_hex_decode.sv | 31 +++
 rtl/display_scan_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package disp_pkg;

  // Per-slot phase: anodes dark, or the selected digit lit.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  // All segments off (active-low pattern).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Width of the per-slot tick counter; holds up to 15 ticks.
  localparam int CNT_W = 4;

  // Width of a digit index for n digits.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low 7-segment glyph, bit order {g,f,e,d,c,b,a}.
module seg7_hex_decode (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Standard hex glyph table; lowercase b and d for 0xB and 0xD.
  always_comb begin
    seg_o = 7'h7F;
    case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller.
// Each digit slot spends BLANK_TICKS refresh ticks with all anodes off, then
// ON_TICKS ticks showing the digit. New display values arrive through a
// valid/ready handshake into a shadow register and are committed only at a
// frame boundary (or immediately while the display is disabled), so a frame
// never mixes old and new digits.
// Optional build macro DISP_LZ_BLANK_EN: leading-zero suppression on digits
// above digit 0 (anode timing unchanged, segments forced off).
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int BLANK_TICKS = 1,
  parameter int ON_TICKS    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  en,
  input  logic                  load_valid,
  input  logic [4*N_DIGITS-1:0] load_data,
  output logic                  load_ready,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int IDX_W = idx_w(N_DIGITS);
  localparam int DW    = 4 * N_DIGITS;

  // Scan FSM and counters
  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   slot_cnt_q;
  logic               frame_done_q;

  // Handshake / shadow registers
  logic [DW-1:0]      disp_q,    disp_d;
  logic [DW-1:0]      pend_q,    pend_d;
  logic               pending_q, pending_d;
  logic               ready_q,   ready_d;

  // Registered pin drivers
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic [CNT_W:0]     cnt_inc;
  logic               blank_last;
  logic               show_last;
  logic               idx_last;
  logic               wrap;
  logic               accept;
  logic               commit;
  logic [3:0]         nib;
  logic [6:0]         glyph;
  logic               lz_off;

  assign cnt_inc    = {1'b0, slot_cnt_q} + 1'b1;
  assign blank_last = (cnt_inc == (CNT_W+1)'(BLANK_TICKS));
  assign show_last  = (cnt_inc == (CNT_W+1)'(ON_TICKS));
  assign idx_last   = (idx_q == IDX_W'(N_DIGITS - 1));

  // The tick that ends the last digit's SHOW phase closes the frame.
  assign wrap = en & tick & (state_q == SHOW) & show_last & idx_last;

  // Scan FSM: slot phase, digit index, tick counter and the frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      slot_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= wrap;
      if (!en) begin
        state_q    <= BLANK;
        idx_q      <= '0;
        slot_cnt_q <= '0;
      end else begin
        case (state_q)
          BLANK: begin
            // With no blank phase configured, BLANK only exists right after
            // enable/reset and hands over to SHOW at once.
            if (BLANK_TICKS == 0) begin
              state_q    <= SHOW;
              slot_cnt_q <= '0;
            end else if (tick) begin
              if (blank_last) begin
                state_q    <= SHOW;
                slot_cnt_q <= '0;
              end else begin
                slot_cnt_q <= slot_cnt_q + 1'b1;
              end
            end
          end
          SHOW: begin
            if (tick) begin
              if (show_last) begin
                slot_cnt_q <= '0;
                state_q    <= (BLANK_TICKS == 0) ? SHOW : BLANK;
                idx_q      <= idx_last ? '0 : idx_q + 1'b1;
              end else begin
                slot_cnt_q <= slot_cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= BLANK;
        endcase
      end
    end
  end

  // A value already pending commits at the frame boundary, or straight away
  // while disabled since nothing is being shown. load_ready mirrors the
  // shadow register being free.
  assign accept = load_valid & ready_q;
  assign commit = pending_q & (~en | wrap);

  // Shadow-register and display-register next state.
  always_comb begin
    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (commit) begin
      disp_d    = pend_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      pend_d    = load_data;
      pending_d = 1'b1;
    end
    ready_d = ~pending_d;
  end

  // Handshake and display registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q    <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
    end
  end

  assign nib = disp_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nib_i (nib),
    .seg_o (glyph)
  );

`ifdef DISP_LZ_BLANK_EN
  // A digit above 0 is a leading zero when it and every higher nibble are 0.
  always_comb begin
    lz_off = 1'b0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if ((idx_q == IDX_W'(i)) && ((disp_q >> (4 * i)) == '0)) begin
        lz_off = 1'b1;
      end
    end
  end
`else
  assign lz_off = 1'b0;
`endif

  // Pin drivers derived from the current FSM state; dark whenever disabled.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    if (en && (state_q == SHOW)) begin
      an_d[idx_q] = 1'b0;
      seg_d       = lz_off ? SEG_OFF : glyph;
    end
  end

  // Output registers: pins lag the FSM by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= SEG_OFF;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign load_ready = ready_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl (N_DIGITS=4, BLANK_TICKS=1, ON_TICKS=2,
// tick every 4 clk). The reference model tracks the scan as a tick position
// within the frame and derives digit/phase arithmetically.
module tb_display_scan_ctrl;

  localparam int N  = 4;
  localparam int BT = 1;
  localparam int OT = 2;
  localparam int PER   = BT + OT;
  localparam int FRAME = N * PER;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        en;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  display_scan_ctrl #(
    .N_DIGITS    (N),
    .BLANK_TICKS (BT),
    .ON_TICKS    (OT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .en         (en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model state
  int          m_tc;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_pending;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_ready;
  logic        e_fd;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  function automatic logic [6:0] digit_seg(input logic [15:0] disp, input int d);
    logic [15:0] upper;
    logic [3:0]  v;
    upper = disp >> (4 * d);
    v     = upper[3:0];
`ifdef DISP_LZ_BLANK_EN
    if (d > 0 && upper == 16'h0) return 7'h7F;
`endif
    return hex_glyph(v);
  endfunction

  task automatic model_reset();
    m_tc      = 0;
    m_disp    = 16'h0;
    m_pend    = 16'h0;
    m_pending = 1'b0;
    e_an      = 4'hF;
    e_seg     = 7'h7F;
    e_ready   = 1'b1;
    e_fd      = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using inputs as sampled.
  task automatic model_edge();
    int         slot;
    int         ph;
    logic [3:0] one;
    bit         wrap;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    if (en) begin
      slot = m_tc / PER;
      ph   = m_tc % PER;
      if (ph >= BT) begin
        one   = 4'b0001 << slot;
        e_an  = ~one;
        e_seg = digit_seg(m_disp, slot);
      end
    end
    wrap = en && tick && (m_tc == FRAME - 1);
    e_fd = wrap;
    if (!en) m_tc = 0;
    else if (tick) m_tc = (m_tc + 1) % FRAME;
    if (m_pending && (!en || wrap)) begin
      m_disp    = m_pend;
      m_pending = 1'b0;
    end else if (load_valid && !m_pending) begin
      m_pend    = load_data;
      m_pending = 1'b1;
    end
    e_ready = !m_pending;
  endtask

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, act, exp, $time);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic check_all();
    chk("an", {12'h0, an}, {12'h0, e_an});
    chk("seg", {9'h0, seg}, {9'h0, e_seg});
    chk("load_ready", {15'h0, load_ready}, {15'h0, e_ready});
    chk("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
  endtask

  // Advance one clock, update the model, sample 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_all();
    cyc++;
    tick = (cyc % 4 == 3);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_an"}, {12'h0, an}, 16'h000F);
    chk({tag, "_seg"}, {9'h0, seg}, 16'h007F);
    chk({tag, "_ready"}, {15'h0, load_ready}, 16'h0001);
    chk({tag, "_fd"}, {15'h0, frame_done}, 16'h0000);
    run(2);
    rst = 1'b0;
  endtask

  int fdc;
  int k;

  initial begin
    rst        = 1'b1;
    tick       = 1'b0;
    en         = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0;
    model_reset();
    run(3);
    chk("reset_an", {12'h0, an}, 16'h000F);
    chk("reset_seg", {9'h0, seg}, 16'h007F);
    chk("reset_ready", {15'h0, load_ready}, 16'h0001);
    rst = 1'b0;
    run(2);

    // Load 1234 while disabled; it commits on the following cycle.
    load_valid = 1'b1;
    load_data  = 16'h1234;
    cycle();
    load_valid = 1'b0;
    chk("ready_after_accept", {15'h0, load_ready}, 16'h0000);
    cycle();
    cycle();
    chk("ready_after_commit", {15'h0, load_ready}, 16'h0001);

    // Scan two full frames.
    en  = 1'b1;
    fdc = 0;
    for (int i = 0; i < 96; i++) begin
      cycle();
      fdc += int'(frame_done);
    end
    chk("frame_done_per_96clk", 16'(fdc), 16'd2);

    // Mid-frame load, then back-pressure with changing data.
    run(20);
    load_valid = 1'b1;
    load_data  = 16'hABCD;
    cycle();
    chk("ready_low_mid_frame", {15'h0, load_ready}, 16'h0000);
    load_data = 16'h5555;
    run(10);
    for (int i = 0; i < 10; i++) begin
      load_data = 16'($urandom);
      cycle();
    end
    load_valid = 1'b0;
    k = 0;
    while (!load_ready && k < 60) begin
      cycle();
      k++;
    end
    chk("ready_returns", {15'h0, load_ready}, 16'h0001);
    run(60);

    // Disable during a SHOW phase.
    k = 0;
    while (an == 4'hF && k < 20) begin
      cycle();
      k++;
    end
    chk("reached_show", {15'h0, an != 4'hF}, 16'h0001);
    en = 1'b0;
    cycle();
    chk("an_dark_after_disable", {12'h0, an}, 16'h000F);
    load_valid = 1'b1;
    load_data  = 16'h0007;
    cycle();
    load_valid = 1'b0;
    run(12);
    en = 1'b1;
    run(60);

    // Leading-zero pattern.
    en         = 1'b0;
    load_valid = 1'b1;
    load_data  = 16'h0070;
    cycle();
    load_valid = 1'b0;
    cycle();
    en = 1'b1;
    run(60);

    // Reset in the middle of a handshake discards the pending value.
    run(17);
    load_valid = 1'b1;
    load_data  = 16'h9E8F;
    cycle();
    load_valid = 1'b0;
    run(3);
    async_reset("async_rst");
    en = 1'b1;
    run(60);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) en = ~en;
      load_valid = ($urandom_range(0, 7) == 0);
      load_data  = 16'($urandom);
      cycle();
      if ($urandom_range(0, 999) == 0) begin
        load_valid = 1'b0;
        async_reset("rand_rst");
      end
    end
    load_valid = 1'b0;
    en = 1'b1;
    run(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
